fir_frame_sequencer: RTL and testbench

Frame-level controller placed in front of and behind a single FIR filter instance (delay line + MAC tree with valid_in/valid_out and no backpressure). Accepts sample frames on a valid/ready/last stream and issues them to the filter. Optionally appends NUM_TAPS-1 zero flush samples so the filter emits the full convolution tail. Counts filter outputs, tags the final one with m_last, reports frame completion, and flags length overflow and a lost-output timeout.

---
 rtl/fir_frame_sequencer_if.sv | 26 ++
 rtl/fir_frame_sequencer.sv | 173 +++++++++++++++++
 tb/tb_fir_frame_sequencer.sv | 279 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/fir_frame_sequencer_if.sv
// Sample stream into the sequencer and filtered stream out of it.
// The sequencer connects to the slave modport; the source/sink connects to the master modport.
interface fir_frame_sequencer_if #(
  parameter int unsigned INPUT_WIDTH  = 16,
  parameter int unsigned OUTPUT_WIDTH = 16
);
  logic                    s_valid;
  logic                    s_ready;
  logic [INPUT_WIDTH-1:0]  s_data;
  logic                    s_last;
  logic                    m_valid;
  logic [OUTPUT_WIDTH-1:0] m_data;
  logic                    m_last;

  modport master (
    output s_valid, s_data, s_last,
    input  s_ready,
    input  m_valid, m_data, m_last
  );

  modport slave (
    input  s_valid, s_data, s_last,
    output s_ready,
    output m_valid, m_data, m_last
  );
endinterface

// File: rtl/fir_frame_sequencer.sv
// Frame controller around one FIR filter: issues input frames, optionally appends a zero flush,
// tags the last filter output, and flags overlong frames and lost outputs.
module fir_frame_sequencer #(
  parameter int unsigned INPUT_WIDTH    = 16,
  parameter int unsigned OUTPUT_WIDTH   = 16,
  parameter int unsigned NUM_TAPS       = 37,
  parameter int unsigned FILTER_LATENCY = 7,
  parameter int unsigned MAX_FRAME      = 1024
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    flush_en,
  fir_frame_sequencer_if.slave    strm,
  output logic                    f_valid_in,
  output logic [INPUT_WIDTH-1:0]  f_din,
  input  logic                    f_valid_out,
  input  logic [OUTPUT_WIDTH-1:0] f_dout,
  output logic                    busy,
  output logic                    frame_done,
  output logic                    err_len,
  output logic                    err_timeout
);

  localparam int unsigned CNT_W     = $clog2(MAX_FRAME + NUM_TAPS);
  localparam int unsigned FLUSH_LEN = NUM_TAPS - 1;
  localparam int unsigned WD_LIMIT  = FILTER_LATENCY + 4;
  localparam int unsigned WD_W      = $clog2(WD_LIMIT + 1);

  localparam logic [1:0] StIdle   = 2'd0;
  localparam logic [1:0] StStream = 2'd1;
  localparam logic [1:0] StFlush  = 2'd2;
  localparam logic [1:0] StDrain  = 2'd3;

  logic [1:0]              state_q, state_d;
  logic                    rdy_q;
  logic [CNT_W-1:0]        in_cnt_q, in_cnt_d;
  logic [CNT_W-1:0]        out_cnt_q, out_cnt_d;
  logic [CNT_W-1:0]        target_q, target_d;
  logic                    flush_q, flush_d;
  logic [WD_W-1:0]         wd_q, wd_d;
  logic                    f_valid_in_q, f_valid_in_d;
  logic [INPUT_WIDTH-1:0]  f_din_q, f_din_d;
  logic                    m_valid_q, m_valid_d;
  logic [OUTPUT_WIDTH-1:0] m_data_q, m_data_d;
  logic                    m_last_q, m_last_d;
  logic                    frame_done_q, frame_done_d;
  logic                    err_len_q, err_len_d;
  logic                    err_timeout_q, err_timeout_d;
  logic                    s_ready;
  logic                    accept;

  // rdy_q keeps s_ready low while reset is held even though the state is already idle
  assign s_ready = rdy_q & ((state_q == StIdle) | (state_q == StStream));
  assign accept  = strm.s_valid & s_ready;

  always_comb begin
    state_d       = state_q;
    in_cnt_d      = in_cnt_q;
    out_cnt_d     = out_cnt_q;
    target_d      = target_q;
    flush_d       = flush_q;
    wd_d          = wd_q;
    f_valid_in_d  = 1'b0;
    f_din_d       = '0;
    m_valid_d     = 1'b0;
    m_data_d      = m_data_q;
    m_last_d      = 1'b0;
    frame_done_d  = 1'b0;
    err_len_d     = err_len_q;
    err_timeout_d = 1'b0;

    // Input side
    if (accept) begin
      f_valid_in_d = 1'b1;
      f_din_d      = strm.s_data;
      in_cnt_d     = in_cnt_q + 1'b1;
      if (state_q == StIdle) begin
        in_cnt_d  = CNT_W'(1);
        out_cnt_d = '0;
        flush_d   = flush_en;
        err_len_d = 1'b0;
        state_d   = StStream;
      end
      if (strm.s_last || (in_cnt_d == CNT_W'(MAX_FRAME))) begin
        if (flush_d && (FLUSH_LEN != 0)) begin
          target_d = in_cnt_d + CNT_W'(FLUSH_LEN);
          state_d  = StFlush;
        end else begin
          target_d = in_cnt_d;
          state_d  = StDrain;
          wd_d     = '0;
        end
        if (!strm.s_last) err_len_d = 1'b1;
      end
    end else if (state_q == StFlush) begin
      f_valid_in_d = 1'b1;
      in_cnt_d     = in_cnt_q + 1'b1;
      if (in_cnt_d == target_q) begin
        state_d = StDrain;
        wd_d    = '0;
      end
    end

    // Output side; state_d already reflects a same-edge entry into drain
    if ((state_q != StIdle) && f_valid_out) begin
      m_valid_d = 1'b1;
      m_data_d  = f_dout;
      out_cnt_d = out_cnt_q + 1'b1;
      if (state_d == StDrain) begin
        wd_d = '0;
        if (out_cnt_d == target_d) begin
          m_last_d     = 1'b1;
          frame_done_d = 1'b1;
          state_d      = StIdle;
        end
      end
    end else if (state_q == StDrain) begin
      wd_d = wd_q + 1'b1;
      if (wd_d == WD_W'(WD_LIMIT)) begin
        err_timeout_d = 1'b1;
        state_d       = StIdle;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= StIdle;
      rdy_q         <= 1'b0;
      in_cnt_q      <= '0;
      out_cnt_q     <= '0;
      target_q      <= '0;
      flush_q       <= 1'b0;
      wd_q          <= '0;
      f_valid_in_q  <= 1'b0;
      f_din_q       <= '0;
      m_valid_q     <= 1'b0;
      m_data_q      <= '0;
      m_last_q      <= 1'b0;
      frame_done_q  <= 1'b0;
      err_len_q     <= 1'b0;
      err_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      rdy_q         <= 1'b1;
      in_cnt_q      <= in_cnt_d;
      out_cnt_q     <= out_cnt_d;
      target_q      <= target_d;
      flush_q       <= flush_d;
      wd_q          <= wd_d;
      f_valid_in_q  <= f_valid_in_d;
      f_din_q       <= f_din_d;
      m_valid_q     <= m_valid_d;
      m_data_q      <= m_data_d;
      m_last_q      <= m_last_d;
      frame_done_q  <= frame_done_d;
      err_len_q     <= err_len_d;
      err_timeout_q <= err_timeout_d;
    end
  end

  assign strm.s_ready = s_ready;
  assign strm.m_valid = m_valid_q;
  assign strm.m_data  = m_data_q;
  assign strm.m_last  = m_last_q;
  assign f_valid_in   = f_valid_in_q;
  assign f_din        = f_din_q;
  assign busy         = (state_q != StIdle);
  assign frame_done   = frame_done_q;
  assign err_len      = err_len_q;
  assign err_timeout  = err_timeout_q;

endmodule

// File: tb/tb_fir_frame_sequencer.sv
// Scoreboard bench for fir_frame_sequencer with an identity filter model of fixed latency.
module tb_fir_frame_sequencer;

  localparam int unsigned IW = 16;
  localparam int unsigned OW = 16;
  localparam int unsigned NT = 37;
  localparam int unsigned FL = 7;
  localparam int unsigned MF = 12;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          flush_en = 1'b0;
  logic          f_valid_in;
  logic [IW-1:0] f_din;
  logic          f_valid_out;
  logic [OW-1:0] f_dout;
  logic          busy, frame_done, err_len, err_timeout;

  fir_frame_sequencer_if #(.INPUT_WIDTH(IW), .OUTPUT_WIDTH(OW)) sif ();

  fir_frame_sequencer #(
    .INPUT_WIDTH   (IW),
    .OUTPUT_WIDTH  (OW),
    .NUM_TAPS      (NT),
    .FILTER_LATENCY(FL),
    .MAX_FRAME     (MF)
  ) dut (
    .clk        (clk),
    .rst        (rst_n),
    .flush_en   (flush_en),
    .strm       (sif),
    .f_valid_in (f_valid_in),
    .f_din      (f_din),
    .f_valid_out(f_valid_out),
    .f_dout     (f_dout),
    .busy       (busy),
    .frame_done (frame_done),
    .err_len    (err_len),
    .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  // Identity filter, FL cycles from valid_in to valid_out; drop_at suppresses one output.
  logic [FL-1:0]         vpipe = '0;
  logic [FL-1:0][IW-1:0] dpipe = '0;
  int                    out_num = 0;
  int                    drop_at = -1;

  assign f_valid_out = vpipe[FL-1] && (out_num != drop_at);
  assign f_dout      = dpipe[FL-1];

  always @(posedge clk) begin
    vpipe <= {vpipe[FL-2:0], f_valid_in};
    dpipe <= {dpipe[FL-2:0], f_din};
    if (vpipe[FL-1]) out_num <= out_num + 1;
  end

  // Scoreboard: {last, data}
  logic [OW:0] exp_q[$];
  int          mv_total = 0;
  int          fvi_total = 0;
  int          fzero_total = 0;
  int          cur_run = 0;
  int          max_run = 0;
  logic        gap_en = 1'b0;
  logic        gap_armed = 1'b0;

  always @(negedge clk) begin
    if (rst_n) begin
      if (f_valid_in) begin
        fvi_total++;
        if (f_din == '0) fzero_total++;
        cur_run++;
        if (cur_run > max_run) max_run = cur_run;
      end else begin
        cur_run = 0;
      end
      if (sif.m_valid) begin
        mv_total++;
        if (exp_q.size() == 0) begin
          chk("unexpected_m_valid", {sif.m_last, sif.m_data}, '1);
        end else begin
          logic [OW:0] e;
          e = exp_q.pop_front();
          chk("m_data", sif.m_data, e[OW-1:0]);
          chk("m_last", sif.m_last, e[OW]);
        end
      end
      if (sif.m_valid || frame_done) chk("frame_done", frame_done, sif.m_valid & sif.m_last);
      if (gap_armed) begin
        chk("gap_restart_busy", busy, 1'b1);
        gap_armed = 1'b0;
        gap_en    = 1'b0;
      end
      if (gap_en && frame_done) begin
        chk("gap_idle_busy", busy, 1'b0);
        gap_armed = 1'b1;
      end
    end
  end

  function automatic void push(input logic [OW-1:0] d, input logic last);
    exp_q.push_back({last, d});
  endfunction

  // Called at a negedge; returns at the negedge following the accepting edge.
  task automatic send(input logic [IW-1:0] d, input logic last);
    int   n;
    logic ok;
    n = 0;
    sif.s_valid = 1'b1;
    sif.s_data  = d;
    sif.s_last  = last;
    while (1) begin
      ok = sif.s_ready;
      @(negedge clk);
      if (ok) break;
      n++;
      if (n > 300) begin
        chk("send_accept_timeout", 0, 1);
        break;
      end
    end
  endtask

  task automatic wait_done(input string tag, output int rdy_hi);
    int n;
    rdy_hi = 0;
    for (n = 0; n < 400; n++) begin
      @(negedge clk);
      if (frame_done) break;
      if (sif.s_ready) rdy_hi++;
    end
    chk({tag, "_done_seen"}, n < 400, 1'b1);
    chk({tag, "_idle_ready"}, {sif.s_ready, busy}, 2'b10);
  endtask

  function automatic logic [39:0] out_vec();
    return {sif.s_ready, f_valid_in, f_din, sif.m_valid, sif.m_data, sif.m_last, busy,
            frame_done, err_len, err_timeout};
  endfunction

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "simulation time limit");
  end

  initial begin
    int rdy_hi, fvi0, fz0, mv0, last_mv, cyc;
    logic got;
    sif.s_valid = 1'b0;
    sif.s_data  = '0;
    sif.s_last  = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    chk("reset_outputs", out_vec(), '0);
    rst_n = 1'b1;
    #1 chk("ready_before_first_edge", sif.s_ready, 1'b0);
    @(negedge clk);
    chk("ready_after_first_edge", {sif.s_ready, busy}, 2'b10);

    // 1: flush frame 1,2,3,4 -> 40 issued, 36 zeros
    flush_en = 1'b1;
    fvi0 = fvi_total; fz0 = fzero_total;
    for (int i = 1; i <= 4; i++) push(OW'(i), 1'b0);
    for (int i = 0; i < 36; i++) push('0, i == 35);
    for (int i = 1; i <= 4; i++) send(IW'(i), i == 4);
    sif.s_valid = 1'b0;
    chk("t1_ready_after_last", {sif.s_ready, busy}, 2'b01);
    wait_done("t1", rdy_hi);
    chk("t1_ready_low_until_idle", rdy_hi, 0);
    chk("t1_fvi_count", fvi_total - fvi0, 40);
    chk("t1_zero_count", fzero_total - fz0, 36);
    chk("t1_fvi_consecutive", max_run, 40);
    chk("t1_err_len", err_len, 1'b0);

    // 2: no flush, 10 samples with gaps
    flush_en = 1'b0;
    @(negedge clk);
    fvi0 = fvi_total; fz0 = fzero_total;
    for (int i = 0; i < 10; i++) begin
      push(OW'(16'h100 + i), i == 9);
      send(IW'(16'h100 + i), i == 9);
      sif.s_valid = 1'b0;
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    wait_done("t2", rdy_hi);
    chk("t2_fvi_count", fvi_total - fvi0, 10);
    chk("t2_zero_count", fzero_total - fz0, 0);
    chk("t2_err_len", err_len, 1'b0);

    // 3: overflow at MF without s_last; next sample waits for idle
    @(negedge clk);
    for (int i = 0; i < MF; i++) push(OW'(16'h200 + i), i == MF - 1);
    for (int i = 0; i < MF; i++) send(IW'(16'h200 + i), 1'b0);
    chk("t3_err_len_set", err_len, 1'b1);
    chk("t3_ready_blocked", sif.s_ready, 1'b0);
    push(OW'(16'h300), 1'b1);
    send(IW'(16'h300), 1'b1);
    sif.s_valid = 1'b0;
    chk("t3_err_len_cleared", err_len, 1'b0);
    wait_done("t3", rdy_hi);

    // 4: third output lost -> watchdog
    @(negedge clk);
    drop_at = out_num + 2;
    mv0 = mv_total;
    for (int i = 1; i <= 5; i++) if (i != 3) push(OW'(16'h40 + i), 1'b0);
    for (int i = 1; i <= 5; i++) send(IW'(16'h40 + i), i == 5);
    sif.s_valid = 1'b0;
    got = 1'b0; last_mv = 0;
    for (cyc = 1; cyc < 300; cyc++) begin
      @(negedge clk);
      if (sif.m_valid) last_mv = cyc;
      if (err_timeout) begin
        got = 1'b1;
        break;
      end
    end
    chk("t4_timeout_seen", got, 1'b1);
    chk("t4_timeout_gap", cyc - last_mv, FL + 4);
    chk("t4_idle_after_timeout", {busy, sif.s_ready, sif.m_last}, 3'b010);
    chk("t4_m_valid_count", mv_total - mv0, 4);
    @(negedge clk);
    chk("t4_timeout_one_cycle", err_timeout, 1'b0);
    drop_at = -1;

    // 5: reset asserted mid-flush
    repeat (3) @(negedge clk);
    flush_en = 1'b1;
    for (int i = 1; i <= 3; i++) send(IW'(16'h50 + i), i == 3);
    sif.s_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("t5_in_flush", {busy, f_valid_in, f_din}, {2'b11, IW'(0)});
    #2 rst_n = 1'b0;
    #1 chk("t5_reset_outputs", out_vec(), '0);
    repeat (2) @(negedge clk);
    mv0 = mv_total;
    rst_n = 1'b1;
    #1 chk("t5_ready_before_edge", sif.s_ready, 1'b0);
    @(negedge clk);
    chk("t5_ready_after_edge", {sif.s_ready, busy}, 2'b10);
    repeat (12) @(negedge clk);
    chk("t5_stray_dropped", mv_total - mv0, 0);

    // 6: single-sample frame then 2-sample frame, one idle cycle between
    flush_en = 1'b0;
    gap_en = 1'b1;
    push(OW'(16'h11), 1'b1);
    push(OW'(16'h21), 1'b0);
    push(OW'(16'h22), 1'b1);
    send(IW'(16'h11), 1'b1);
    send(IW'(16'h21), 1'b0);
    send(IW'(16'h22), 1'b1);
    sif.s_valid = 1'b0;
    wait_done("t6", rdy_hi);
    chk("t6_gap_checked", {gap_en, gap_armed}, 2'b00);

    repeat (20) @(negedge clk);
    chk("scoreboard_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
